// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default timing constants for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned DEF_TICK_DIV  = 250000;
  localparam int unsigned DEF_ON_TICKS  = 40;
  localparam int unsigned DEF_GAP_TICKS = 40;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks; clr restarts the phase.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not gated by clr: clr is derived from transitions that this tick causes.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed high/low output phases, queueing events that arrive mid-cycle.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
  parameter int unsigned PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              ovf_clr,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam int unsigned TW = $clog2(max_u(ON_TICKS, GAP_TICKS) + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_e            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;

  logic tick, presc_clr;
  logic want, start, take, accept, drop;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Phase sequencing: a start consumes one event, either from the queue or directly from pulse_in.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    start   = 1'b0;
    want    = pulse_in || (pend_q != '0);
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        start  = want;
      end
      ON: begin
        if (tick) begin
          if (tcnt_q == ON_LAST) begin
            state_d = GAP;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_d = '0;
            if (want) begin
              start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
    if (start) begin
      state_d = ON;
      tcnt_d  = '0;
    end
  end

  // GAP->ON re-entry counts as a transition even though both sides differ from IDLE.
  assign presc_clr = (state_q == IDLE) || (state_d != state_q) || start;

  // Event queue and sticky overflow; a drop in the same cycle as ovf_clr keeps ovf set.
  always_comb begin
    take   = start && (pend_q != '0);
    accept = pulse_in && !(start && (pend_q == '0));
    drop   = accept && !take && (pend_q == PEND_MAX);
    pend_d = pend_q;
    if (take && !accept) begin
      pend_d = pend_q - PEND_W'(1);
    end else if (accept && !take && !drop) begin
      pend_d = pend_q + PEND_W'(1);
    end
    ovf_d  = drop || (ovf_q && !ovf_clr);
    out_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios plus random traffic against a cycle-budget model.
module tb_pulse_stretcher;

  localparam int unsigned TD  = 4;
  localparam int unsigned ONT = 3;
  localparam int unsigned GPT = 2;
  localparam int unsigned PW  = 2;
  localparam int ON_CYC  = ONT * TD;
  localparam int GAP_CYC = GPT * TD;
  localparam int PMAX    = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse_in = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          out, busy, ovf;
  logic [PW-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .TICK_DIV  (TD),
    .ON_TICKS  (ONT),
    .GAP_TICKS (GPT),
    .PEND_W    (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .ovf_clr  (ovf_clr),
    .out      (out),
    .busy     (busy),
    .pending  (pending),
    .ovf      (ovf)
  );

  // Reference model: remaining cycles in the current phase plus an event count.
  bit m_busy, m_on, m_ovf;
  int m_rem, m_pend;
  bit s_start, s_drop, s_end_on, s_idle;
  int s_p;

  always_comb begin
    s_start  = 1'b0;
    s_end_on = 1'b0;
    s_idle   = 1'b0;
    if (!m_busy) s_start = pulse_in || (m_pend > 0);
    else if (m_rem == 1) begin
      if (m_on) s_end_on = 1'b1;
      else if (pulse_in || (m_pend > 0)) s_start = 1'b1;
      else s_idle = 1'b1;
    end
    s_p    = m_pend;
    s_drop = 1'b0;
    if (s_start && (m_pend > 0)) s_p = s_p - 1;
    if (pulse_in && !(s_start && (m_pend == 0))) begin
      if (s_p == PMAX) s_drop = 1'b1;
      else s_p = s_p + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_on <= 1'b0; m_ovf <= 1'b0; m_rem <= 0; m_pend <= 0;
    end else begin
      if (s_start) begin
        m_busy <= 1'b1; m_on <= 1'b1; m_rem <= ON_CYC;
      end else if (s_end_on) begin
        m_on <= 1'b0; m_rem <= GAP_CYC;
      end else if (s_idle) begin
        m_busy <= 1'b0; m_rem <= 0;
      end else if (m_busy) begin
        m_rem <= m_rem - 1;
      end
      m_pend <= s_p;
      m_ovf  <= s_drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
  end

  task automatic cyc(input logic p, input logic c);
    pulse_in = p;
    ovf_clr  = c;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out, busy, pending, ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%b busy=%b pending=%0d ovf=%b, required all 0",
               out, busy, pending, ovf);
    end
    rst_n = 1'b1;
    repeat (9) cyc(1'b0, 1'b0);
  endtask

  task automatic test_single();
    int ocnt, bcnt, pmax;
    cyc(1'b1, 1'b0);
    n_checks++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: out=%b one edge after pulse, required 1", out);
    end
    ocnt = int'(out); bcnt = int'(busy); pmax = int'(pending);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0);
      ocnt += int'(out);
      bcnt += int'(busy);
      if (int'(pending) > pmax) pmax = int'(pending);
    end
    n_checks++;
    if (ocnt != ON_CYC) begin
      n_fail++;
      $display("FAIL single_out_len: got %0d cycles, required %0d", ocnt, ON_CYC);
    end
    n_checks++;
    if (bcnt != ON_CYC + GAP_CYC) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d cycles, required %0d", bcnt, ON_CYC + GAP_CYC);
    end
    n_checks++;
    if (pmax != 0) begin
      n_fail++;
      $display("FAIL single_pending: max %0d, required 0", pmax);
    end
  endtask

  task automatic test_back_to_back();
    int rises = 0, hrun = 0, grun = 0;
    int hmin = 1000, hmax = 0, gmin = 1000, gmax = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc(i < 3, 1'b0);
      if (i == 1 || i == 2) begin
        n_checks++;
        if (pending !== PW'(i)) begin
          n_fail++;
          $display("FAIL b2b_pending_%0d: got %0d, required %0d", i, pending, i);
        end
      end
      if (out) begin
        if (!prev) begin
          rises++;
          if (grun > 0) begin
            if (grun < gmin) gmin = grun;
            if (grun > gmax) gmax = grun;
          end
          grun = 0;
        end
        hrun++;
      end else begin
        if (prev) begin
          if (hrun < hmin) hmin = hrun;
          if (hrun > hmax) hmax = hrun;
          hrun = 0;
        end
        if (busy) grun++;
        else grun = 0;
      end
      prev = out;
      if (i > 3 && !busy) break;
    end
    n_checks++;
    if (rises != 3) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d out pulses, required 3", rises);
    end
    n_checks++;
    if (hmin != ON_CYC || hmax != ON_CYC) begin
      n_fail++;
      $display("FAIL b2b_high: lengths %0d..%0d, required %0d", hmin, hmax, ON_CYC);
    end
    n_checks++;
    if (gmin != GAP_CYC || gmax != GAP_CYC) begin
      n_fail++;
      $display("FAIL b2b_gap: lengths %0d..%0d, required %0d", gmin, gmax, GAP_CYC);
    end
    wait_idle();
  endtask

  task automatic test_saturate();
    int rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(i < 5, 1'b0);
      if (i == 3) begin
        n_checks++;
        if (pending !== PW'(3) || ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_fill: pending=%0d ovf=%b, required 3/0", pending, ovf);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (pending !== PW'(3) || ovf !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_drop: pending=%0d ovf=%b, required 3/1", pending, ovf);
        end
      end
      if (out && !prev) rises++;
      prev = out;
      if (i > 5 && !busy) break;
    end
    n_checks++;
    if (rises != 4) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d out pulses, required 4", rises);
    end
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_sticky: ovf=%b after drain, required 1", ovf);
    end
    cyc(1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: ovf=%b after ovf_clr, required 0", ovf);
    end
    wait_idle();
  endtask

  task automatic test_last_gap();
    int low = 0, pmax = 0;
    bit fired = 1'b0, done = 1'b0, dropped_busy = 1'b0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 100 && !done; i++) begin
      fired = (low == GAP_CYC);
      cyc(fired, 1'b0);
      if (int'(pending) > pmax) pmax = int'(pending);
      if (!busy) dropped_busy = 1'b1;
      if (!out) low++;
      else if (fired) done = 1'b1;
    end
    n_checks++;
    if (!done || low != GAP_CYC) begin
      n_fail++;
      $display("FAIL last_gap_len: reentered=%b gap=%0d, required 1/%0d", done, low, GAP_CYC);
    end
    n_checks++;
    if (pmax != 0 || dropped_busy) begin
      n_fail++;
      $display("FAIL last_gap_queue: max pending %0d idle_seen=%b, required 0/0", pmax, dropped_busy);
    end
    wait_idle();
  endtask

  task automatic test_ovf_clr_drop();
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 4);
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b, required 1", ovf);
    end
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_later_clr: ovf=%b, required 0", ovf);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    n_checks++;
    if (out !== 1'b1 || pending !== PW'(2)) begin
      n_fail++;
      $display("FAIL rst_setup: out=%b pending=%0d, required 1/2", out, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out, busy, pending, ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_async: out=%b busy=%b pending=%0d ovf=%b, required all 0",
               out, busy, pending, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'b0);
      if (out || busy) hits++;
    end
    n_checks++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL rst_quiet: %0d active cycles after reset, required 0", hits);
    end
  endtask

  task automatic test_random();
    int dens = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) dens = $urandom_range(2, 30);
      cyc($urandom_range(0, dens - 1) == 0, $urandom_range(0, 40) == 0);
      n_checks++;
      if (out !== m_on || busy !== m_busy || pending !== PW'(m_pend) || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL random_cyc%0d: out=%b busy=%b pend=%0d ovf=%b, required %b %b %0d %b",
                 i, out, busy, pending, ovf, m_on, m_busy, m_pend, m_ovf);
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_last_gap();
    test_ovf_clr_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
